// File: rtl/vga_frame_scanner.sv
// VGA frame scanner: pixel-rate H/V counters, VRAM address issue, a sync/blank delay
// line matched to the VRAM read latency, and 1-bit to 24-bit colour expansion.
module vga_frame_scanner #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          RD_LATENCY = 2,
    parameter logic [23:0] FG_COLOR   = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic [10:0] Fila,
    output logic [10:0] Columna,
    output logic        Rd_en,
    input  logic        Pixel,
    output logic [7:0]  VGA_PixelR,
    output logic [7:0]  VGA_PixelG,
    output logic [7:0]  VGA_PixelB,
    output logic        VGA_Clk,
    output logic        VGA_sync,
    output logic        VGA_blank,
    output logic        Hsync,
    output logic        Vsync,
    output logic        Frame_start
);
    localparam int          DL       = RD_LATENCY;
    localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SB_C   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE_C   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] H_LAST_C = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_ACT_C  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SB_C   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE_C   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] V_LAST_C = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    // Blanked pixels are forced to black regardless of the framebuffer bit.
    function automatic logic [23:0] expand_color(input logic active, input logic bit_i);
        logic [23:0] rgb;
        rgb = '0;
        if (active) begin
            rgb = bit_i ? FG_COLOR : BG_COLOR;
        end
        return rgb;
    endfunction

    logic          pixen_q, pixen_d;
    logic [10:0]   h_q, h_d;
    logic [10:0]   v_q, v_d;
    logic          raw_act, raw_hs, raw_vs, raw_first;
    logic [DL-1:0] dl_act_q, dl_act_d;
    logic [DL-1:0] dl_hs_q, dl_hs_d;
    logic [DL-1:0] dl_vs_q, dl_vs_d;
    logic [DL-1:0] dl_first_q, dl_first_d;
    logic          tail_act, tail_hs, tail_vs, tail_first;
    logic [23:0]   rgb_q, rgb_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          blank_q, blank_d;
    logic          fs_q, fs_d;
    logic          vclk_q, vclk_d;

    // ---- Address stage: pixel enable and raster counters ----
    always_comb begin
        pixen_d = ~pixen_q;
        h_d     = h_q;
        v_d     = v_q;
        if (pixen_q) begin
            if (h_q == H_LAST_C) begin
                h_d = '0;
                v_d = (v_q == V_LAST_C) ? 11'd0 : v_q + 11'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pixen_q <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            pixen_q <= pixen_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    assign raw_act   = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    assign raw_hs    = ~((h_q >= H_SB_C) && (h_q <= H_SE_C));
    assign raw_vs    = ~((v_q >= V_SB_C) && (v_q <= V_SE_C));
    assign raw_first = (h_q == 11'd0) && (v_q == 11'd0);

    assign Fila    = v_q;
    assign Columna = h_q;
    assign Rd_en   = raw_act;

    // ---- Delay line: timing flags wait out the VRAM read latency ----
    always_comb begin
        dl_act_d   = dl_act_q;
        dl_hs_d    = dl_hs_q;
        dl_vs_d    = dl_vs_q;
        dl_first_d = dl_first_q;
        if (pixen_q) begin
            dl_act_d   = DL'({dl_act_q, raw_act});
            dl_hs_d    = DL'({dl_hs_q, raw_hs});
            dl_vs_d    = DL'({dl_vs_q, raw_vs});
            dl_first_d = DL'({dl_first_q, raw_first});
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            dl_act_q   <= '0;
            dl_hs_q    <= '1;
            dl_vs_q    <= '1;
            dl_first_q <= '0;
        end else begin
            dl_act_q   <= dl_act_d;
            dl_hs_q    <= dl_hs_d;
            dl_vs_q    <= dl_vs_d;
            dl_first_q <= dl_first_d;
        end
    end

    assign tail_act   = dl_act_q[DL-1];
    assign tail_hs    = dl_hs_q[DL-1];
    assign tail_vs    = dl_vs_q[DL-1];
    assign tail_first = dl_first_q[DL-1];

    // ---- Output stage: colour, sync and blank registered together ----
    always_comb begin
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        blank_d = blank_q;
        fs_d    = 1'b0;
        vclk_d  = ~pixen_q;
        if (pixen_q) begin
            rgb_d   = expand_color(tail_act, Pixel);
            hsync_d = tail_hs;
            vsync_d = tail_vs;
            blank_d = tail_act;
            fs_d    = tail_first;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
            vclk_q  <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
            vclk_q  <= vclk_d;
        end
    end

    assign VGA_PixelR  = rgb_q[23:16];
    assign VGA_PixelG  = rgb_q[15:8];
    assign VGA_PixelB  = rgb_q[7:0];
    assign Hsync       = hsync_q;
    assign Vsync       = vsync_q;
    assign VGA_blank   = blank_q;
    assign Frame_start = fs_q;
    assign VGA_Clk     = vclk_q;
    assign VGA_sync    = 1'b0;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench for vga_frame_scanner: a full-size 640x480 instance and a shrunken raster with
// RD_LATENCY=4, both checked every Clk against a tick-count raster model.
module tb_vga_frame_scanner;
    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        pix     [2];
    logic [10:0] fila    [2];
    logic [10:0] columna [2];
    logic        rd_en   [2];
    logic [7:0]  red     [2];
    logic [7:0]  grn     [2];
    logic [7:0]  blu     [2];
    logic        vclk    [2];
    logic        syncpin [2];
    logic        blank   [2];
    logic        hsync   [2];
    logic        vsync   [2];
    logic        fstart  [2];

    int HA [2] = '{640, 40};
    int HF [2] = '{16, 4};
    int HS [2] = '{96, 8};
    int HB [2] = '{48, 6};
    int VA [2] = '{480, 12};
    int VF [2] = '{10, 2};
    int VS [2] = '{2, 2};
    int VB [2] = '{33, 3};
    int LAT [2] = '{2, 4};
    // Hand-derived timing landmarks for each raster.
    int HS_FIRST [2] = '{659, 49};
    int HS_LEN   [2] = '{96, 8};
    int BL_LEN   [2] = '{640, 40};
    int VS_LEN   [2] = '{1600, 116};
    int FS_FIRST [2] = '{6, 10};
    int FS_PER   [2] = '{840000, 2204};

    int hs_run [2];
    int bl_run [2];
    int vs_run [2];
    int last_fs [2];
    bit seen_hs [2];

    int          e = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          mode = 0;
    logic [31:0] seed = 32'h0;
    logic        vq0 [$];
    logic        vq1 [$];

    always #5 Clk = ~Clk;

    vga_frame_scanner #(.RD_LATENCY(2)) u_dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .Fila(fila[0]), .Columna(columna[0]), .Rd_en(rd_en[0]),
        .Pixel(pix[0]), .VGA_PixelR(red[0]), .VGA_PixelG(grn[0]), .VGA_PixelB(blu[0]),
        .VGA_Clk(vclk[0]), .VGA_sync(syncpin[0]), .VGA_blank(blank[0]), .Hsync(hsync[0]),
        .Vsync(vsync[0]), .Frame_start(fstart[0])
    );

    vga_frame_scanner #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .RD_LATENCY(4)
    ) u_dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .Fila(fila[1]), .Columna(columna[1]), .Rd_en(rd_en[1]),
        .Pixel(pix[1]), .VGA_PixelR(red[1]), .VGA_PixelG(grn[1]), .VGA_PixelB(blu[1]),
        .VGA_Clk(vclk[1]), .VGA_sync(syncpin[1]), .VGA_blank(blank[1]), .Hsync(hsync[1]),
        .Vsync(vsync[1]), .Frame_start(fstart[1])
    );

    // Clk edges seen since reset release; the pixel tick count is half of this.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) e <= 0;
        else        e <= e + 1;
    end

    function automatic logic hashf(input logic [10:0] r, input logic [10:0] c);
        logic [31:0] x;
        x = {10'd0, r, c} ^ seed;
        x = x * 32'h9E3779B1;
        x = x ^ (x >> 15);
        return x[20];
    endfunction

    // Framebuffer contents for the current stimulus mode.
    function automatic logic vram_bit(input logic [10:0] r, input logic [10:0] c);
        logic b;
        case (mode)
            0:       b = c[0];
            1:       b = 1'b1;
            default: b = hashf(r, c);
        endcase
        return b;
    endfunction

    task automatic check(input string nm, input int k, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t: got %0h, expected %0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic check_inst(input int k);
        int          n, m, col, row, mc, mr, ht, vt, ft;
        logic        act, hs, vs, fs, ract;
        logic [23:0] rgb_exp, rgb_act;
        ht = HA[k] + HF[k] + HS[k] + HB[k];
        vt = VA[k] + VF[k] + VS[k] + VB[k];
        ft = ht * vt;
        n = e / 2;
        col = n % ht;
        row = (n / ht) % vt;
        ract = (col < HA[k]) && (row < VA[k]);
        m = n - LAT[k] - 1;
        act = 1'b0; hs = 1'b1; vs = 1'b1; fs = 1'b0; rgb_exp = '0;
        if (m >= 0) begin
            mc = m % ht;
            mr = (m / ht) % vt;
            act = (mc < HA[k]) && (mr < VA[k]);
            hs = !((mc >= HA[k] + HF[k]) && (mc < HA[k] + HF[k] + HS[k]));
            vs = !((mr >= VA[k] + VF[k]) && (mr < VA[k] + VF[k] + VS[k]));
            fs = (e % 2 == 0) && (m % ft == 0);
            if (act && vram_bit(11'(mr), 11'(mc))) rgb_exp = 24'hFFFFFF;
        end
        rgb_act = {red[k], grn[k], blu[k]};
        check("addr", k, 64'({fila[k], columna[k], rd_en[k]}), 64'({11'(row), 11'(col), ract}));
        check("video", k, 64'({rgb_act, blank[k], hsync[k], vsync[k]}), 64'({rgb_exp, act, hs, vs}));
        check("ctl", k, 64'({vclk[k], syncpin[k], fstart[k]}), 64'({1'(e % 2), 1'b0, fs}));

        if (!Rst_n) begin
            hs_run[k] = 0; bl_run[k] = 0; vs_run[k] = 0; last_fs[k] = -1; seen_hs[k] = 1'b0;
        end else begin
            if (e == 1) check("col_before_tick", k, 64'(columna[k]), 64'd0);
            if (e == 2) check("col_first_tick", k, 64'(columna[k]), 64'd1);
            if (mode == 0 && e == 2 * (LAT[k] + 1)) check("first_vis_black", k, 64'(rgb_act), 64'h0);
            if (mode == 0 && e == 2 * (LAT[k] + 2)) check("second_vis_white", k, 64'(rgb_act), 64'hFFFFFF);
            if (fstart[k]) begin
                if (last_fs[k] < 0) check("fs_first_edge", k, 64'(e), 64'(FS_FIRST[k]));
                else check("fs_period", k, 64'(cyc - last_fs[k]), 64'(FS_PER[k]));
                last_fs[k] = cyc;
            end
            if (e > 0 && e % 2 == 0) begin
                if (!hsync[k]) begin
                    if (!seen_hs[k]) begin
                        check("hs_first_fall", k, 64'(n), 64'(HS_FIRST[k]));
                        seen_hs[k] = 1'b1;
                    end
                    hs_run[k]++;
                end else if (hs_run[k] > 0) begin
                    check("hs_low_len", k, 64'(hs_run[k]), 64'(HS_LEN[k]));
                    hs_run[k] = 0;
                end
                if (blank[k]) bl_run[k]++;
                else if (bl_run[k] > 0) begin
                    check("blank_len", k, 64'(bl_run[k]), 64'(BL_LEN[k]));
                    bl_run[k] = 0;
                end
                if (!vsync[k]) vs_run[k]++;
                else if (vs_run[k] > 0) begin
                    check("vs_low_len", k, 64'(vs_run[k]), 64'(VS_LEN[k]));
                    vs_run[k] = 0;
                end
            end
        end
    endtask

    // VRAM: answer each address sampled at a tick RD_LATENCY ticks later; junk elsewhere.
    task automatic drive_vram();
        logic junk0, junk1;
        junk0 = (mode == 1) ? 1'b1 : 1'($urandom);
        junk1 = (mode == 1) ? 1'b1 : 1'($urandom);
        if (Rst_n && (e % 2 == 1)) begin
            vq0.push_back(vram_bit(fila[0], columna[0]));
            if (vq0.size() > LAT[0] + 1) void'(vq0.pop_front());
            pix[0] = (vq0.size() == LAT[0] + 1) ? vq0[0] : junk0;
            vq1.push_back(vram_bit(fila[1], columna[1]));
            if (vq1.size() > LAT[1] + 1) void'(vq1.pop_front());
            pix[1] = (vq1.size() == LAT[1] + 1) ? vq1[0] : junk1;
        end else begin
            if (!Rst_n) begin
                vq0.delete();
                vq1.delete();
            end
            pix[0] = junk0;
            pix[1] = junk1;
        end
    endtask

    always @(negedge Clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) check_inst(k);
        drive_vram();
    end

    initial begin
        pix[0] = 1'b0;
        pix[1] = 1'b0;
        Rst_n = 1'b1;
        seed = $urandom;
        #1 Rst_n = 1'b0;
        repeat (5) @(posedge Clk);
        #2 Rst_n = 1'b1;
        // Column-parity framebuffer, then a reset in the middle of a line.
        repeat (3600) @(posedge Clk);
        for (int i = 0; i < 2000; i++) begin
            @(posedge Clk);
            #1;
            if (e % 2 == 0 && (e / 2) % 800 == 300) break;
        end
        #1 Rst_n = 1'b0;
        repeat (3) @(posedge Clk);
        mode = 1;
        #2 Rst_n = 1'b1;
        // Constant-one framebuffer, reset at a random point.
        repeat (3400 + $urandom_range(0, 1200)) @(posedge Clk);
        #2 Rst_n = 1'b0;
        repeat (3) @(posedge Clk);
        mode = 2;
        seed = $urandom;
        #2 Rst_n = 1'b1;
        // Pseudo-random framebuffer over many small-raster frames.
        repeat (30000) @(posedge Clk);
        @(negedge Clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
